// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic phase controller.
// TLC_NIGHT_FLASH_EN adds the FLASH state used by the night-flash mode.
package tlc_pkg;

    // Width of the seconds countdown shown on the display
    localparam int CD_W = 7;

    // One-hot lamp encodings {red, yellow, green}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_1  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_2  = 3'd5,
        PED_WALK  = 3'd6
`ifdef TLC_NIGHT_FLASH_EN
        , FLASH   = 3'd7
`endif
    } tlc_state_e;

endpackage

// File: rtl/traffic_phase_ctrl_tick_gen.sv
// One-cycle strobe every TICK_DIV clk_20 cycles; restart realigns the
// divider so a new phase always starts a full second before its first tick.
module tick_gen #(
    parameter int TICK_DIV = 20000000
) (
    input  logic clk_20,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Divider counter: wraps at CNT_MAX, forced to zero on restart
    always_ff @(posedge clk_20) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_restart || (r_cnt == CNT_MAX)) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == CNT_MAX);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer with pedestrian crossing.
// Optional night flashing mode is enabled by defining TLC_NIGHT_FLASH_EN.
module traffic_phase_ctrl
    import tlc_pkg::*;
#(
    parameter int TICK_DIV   = 20000000,
    parameter int GREEN_NS_S = 25,
    parameter int GREEN_EW_S = 15,
    parameter int YELLOW_S   = 3,
    parameter int ALLRED_S   = 1,
    parameter int WALK_S     = 10
) (
    input  logic            clk_20,
    input  logic            rst_n,
    input  logic            i_car_ew,
    input  logic            i_ped_btn,
`ifdef TLC_NIGHT_FLASH_EN
    input  logic            i_night_mode,
`endif
    output logic [2:0]      o_ns_lamp,
    output logic [2:0]      o_ew_lamp,
    output logic            o_walk,
    output logic [CD_W-1:0] o_countdown,
    output logic            o_tick
);

    tlc_state_e      r_state, w_next_state;
    logic [CD_W-1:0] r_timer, w_next_timer;
    logic            r_ped_pending, w_next_ped;
    logic [2:0]      r_ns_lamp, w_next_ns;
    logic [2:0]      r_ew_lamp, w_next_ew;
    logic            r_walk, w_next_walk;
    logic            w_tick, w_restart, w_phase_end;
`ifdef TLC_NIGHT_FLASH_EN
    logic            r_flash_lit, w_next_flash_lit;
`endif

    // Timer reload value (duration minus one) for each phase
    function automatic logic [CD_W-1:0] phase_len_m1(input tlc_state_e s);
        case (s)
            NS_GREEN:  return CD_W'(GREEN_NS_S - 1);
            NS_YELLOW: return CD_W'(YELLOW_S - 1);
            ALLRED_1:  return CD_W'(ALLRED_S - 1);
            EW_GREEN:  return CD_W'(GREEN_EW_S - 1);
            EW_YELLOW: return CD_W'(YELLOW_S - 1);
            ALLRED_2:  return CD_W'(ALLRED_S - 1);
            PED_WALK:  return CD_W'(WALK_S - 1);
            default:   return {CD_W{1'b0}};
        endcase
    endfunction

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk_20    (clk_20),
        .rst_n     (rst_n),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    // Next-state selection; transitions only happen on a tick
    always_comb begin
        w_next_state = r_state;
        w_phase_end  = w_tick && (r_timer == {CD_W{1'b0}});
        case (r_state)
            NS_GREEN: begin
                if (w_phase_end && (i_car_ew || r_ped_pending)) w_next_state = NS_YELLOW;
                else                                             w_next_state = r_state;
            end
            NS_YELLOW: begin
                if (w_phase_end) w_next_state = ALLRED_1;
                else             w_next_state = r_state;
            end
            ALLRED_1: begin
                if (w_phase_end) begin
`ifdef TLC_NIGHT_FLASH_EN
                    if (i_night_mode) w_next_state = FLASH;
                    else
`endif
                    if (i_car_ew) w_next_state = EW_GREEN;
                    else          w_next_state = PED_WALK;
                end else begin
                    w_next_state = r_state;
                end
            end
            EW_GREEN: begin
                if (w_phase_end) w_next_state = EW_YELLOW;
                else             w_next_state = r_state;
            end
            EW_YELLOW: begin
                if (w_phase_end) w_next_state = ALLRED_2;
                else             w_next_state = r_state;
            end
            ALLRED_2: begin
                if (w_phase_end) begin
`ifdef TLC_NIGHT_FLASH_EN
                    if (i_night_mode) w_next_state = FLASH;
                    else
`endif
                    if (r_ped_pending) w_next_state = PED_WALK;
                    else               w_next_state = NS_GREEN;
                end else begin
                    w_next_state = r_state;
                end
            end
            PED_WALK: begin
                if (w_phase_end) w_next_state = NS_GREEN;
                else             w_next_state = r_state;
            end
`ifdef TLC_NIGHT_FLASH_EN
            FLASH: begin
                if (w_tick && !i_night_mode) w_next_state = ALLRED_2;
                else                         w_next_state = r_state;
            end
`endif
            default: w_next_state = NS_GREEN;
        endcase
    end

    assign w_restart = (w_next_state != r_state);

    // Timer, pedestrian latch and lamp values for the coming cycle
    always_comb begin
        w_next_timer = r_timer;
        w_next_ped   = r_ped_pending;
        w_next_ns    = LAMP_RED;
        w_next_ew    = LAMP_RED;
        w_next_walk  = 1'b0;
`ifdef TLC_NIGHT_FLASH_EN
        w_next_flash_lit = r_flash_lit;
`endif

        // Reload on entry; otherwise count down and rest at zero
        if (w_restart) begin
            w_next_timer = phase_len_m1(w_next_state);
        end else if (w_tick && (r_timer != {CD_W{1'b0}})) begin
            w_next_timer = r_timer - CD_W'(1);
        end else begin
            w_next_timer = r_timer;
        end

        // Clearing on walk entry beats a simultaneous press
        if (w_restart && (w_next_state == PED_WALK)) begin
            w_next_ped = 1'b0;
        end else if (i_ped_btn && (r_state != PED_WALK)) begin
            w_next_ped = 1'b1;
        end else begin
            w_next_ped = r_ped_pending;
        end

`ifdef TLC_NIGHT_FLASH_EN
        // Flash starts lit on entry and toggles every tick
        if (w_restart && (w_next_state == FLASH)) begin
            w_next_flash_lit = 1'b1;
        end else if ((r_state == FLASH) && w_tick) begin
            w_next_flash_lit = ~r_flash_lit;
        end else begin
            w_next_flash_lit = r_flash_lit;
        end
`endif

        case (w_next_state)
            NS_GREEN:  begin w_next_ns = LAMP_GRN; w_next_ew = LAMP_RED; end
            NS_YELLOW: begin w_next_ns = LAMP_YEL; w_next_ew = LAMP_RED; end
            EW_GREEN:  begin w_next_ns = LAMP_RED; w_next_ew = LAMP_GRN; end
            EW_YELLOW: begin w_next_ns = LAMP_RED; w_next_ew = LAMP_YEL; end
            PED_WALK:  begin w_next_ns = LAMP_RED; w_next_ew = LAMP_RED; w_next_walk = 1'b1; end
`ifdef TLC_NIGHT_FLASH_EN
            FLASH: begin
                if (w_next_flash_lit) begin
                    w_next_ns = LAMP_YEL;
                    w_next_ew = LAMP_RED;
                end else begin
                    w_next_ns = LAMP_OFF;
                    w_next_ew = LAMP_OFF;
                end
            end
`endif
            default:   begin w_next_ns = LAMP_RED; w_next_ew = LAMP_RED; end
        endcase
    end

    // State, timer, latch and registered lamp outputs
    always_ff @(posedge clk_20) begin
        if (!rst_n) begin
            r_state       <= NS_GREEN;
            r_timer       <= CD_W'(GREEN_NS_S - 1);
            r_ped_pending <= 1'b0;
            r_ns_lamp     <= LAMP_GRN;
            r_ew_lamp     <= LAMP_RED;
            r_walk        <= 1'b0;
`ifdef TLC_NIGHT_FLASH_EN
            r_flash_lit   <= 1'b0;
`endif
        end else begin
            r_state       <= w_next_state;
            r_timer       <= w_next_timer;
            r_ped_pending <= w_next_ped;
            r_ns_lamp     <= w_next_ns;
            r_ew_lamp     <= w_next_ew;
            r_walk        <= w_next_walk;
`ifdef TLC_NIGHT_FLASH_EN
            r_flash_lit   <= w_next_flash_lit;
`endif
        end
    end

    assign o_ns_lamp   = r_ns_lamp;
    assign o_ew_lamp   = r_ew_lamp;
    assign o_walk      = r_walk;
    assign o_countdown = r_timer;
    assign o_tick      = w_tick;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed, table-driven bench for traffic_phase_ctrl with short timings.
module tb_traffic_phase_ctrl;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] O = 3'b000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       car = 1'b0;
    logic       ped = 1'b0;
`ifdef TLC_NIGHT_FLASH_EN
    logic       night = 1'b0;
`endif
    logic [2:0] ns_lamp, ew_lamp;
    logic       walk, tick;
    logic [6:0] cd;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic       car;
        int         ped;   // 0 none, 1 first cycle only, 2 whole record
        int         n;     // cycles in this record
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
        int         cd0;   // countdown at first cycle
    } vec_t;

    vec_t tbl[29];

    traffic_phase_ctrl #(
        .TICK_DIV(4), .GREEN_NS_S(3), .GREEN_EW_S(2),
        .YELLOW_S(2), .ALLRED_S(1), .WALK_S(2)
    ) dut (
        .clk_20      (clk),
        .rst_n       (rst_n),
        .i_car_ew    (car),
        .i_ped_btn   (ped),
`ifdef TLC_NIGHT_FLASH_EN
        .i_night_mode(night),
`endif
        .o_ns_lamp   (ns_lamp),
        .o_ew_lamp   (ew_lamp),
        .o_walk      (walk),
        .o_countdown (cd),
        .o_tick      (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leaves the bench at the negedge of the first cycle after reset release
    task automatic do_reset();
        rst_n = 1'b0;
        car   = 1'b0;
        ped   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic c, input int p, input int n,
                                input logic [2:0] nsv, input logic [2:0] ewv,
                                input logic w, input int c0);
        vec_t v;
        v.car = c; v.ped = p; v.n = n; v.ns = nsv; v.ew = ewv; v.walk = w; v.cd0 = c0;
        return v;
    endfunction

    initial begin
        int e;
        // car-driven EW cycle
        tbl[0]  = mk(1'b1, 0, 12, G, R, 1'b0, 2);
        tbl[1]  = mk(1'b1, 0,  8, Y, R, 1'b0, 1);
        tbl[2]  = mk(1'b1, 0,  4, R, R, 1'b0, 0);
        tbl[3]  = mk(1'b0, 0,  8, R, G, 1'b0, 1);
        tbl[4]  = mk(1'b0, 0,  8, R, Y, 1'b0, 1);
        tbl[5]  = mk(1'b0, 0,  4, R, R, 1'b0, 0);
        // single ped pulse after green minimum
        tbl[6]  = mk(1'b0, 0, 20, G, R, 1'b0, 2);
        tbl[7]  = mk(1'b0, 1,  4, G, R, 1'b0, 0);
        tbl[8]  = mk(1'b0, 0,  8, Y, R, 1'b0, 1);
        tbl[9]  = mk(1'b0, 0,  4, R, R, 1'b0, 0);
        tbl[10] = mk(1'b0, 0,  8, R, R, 1'b1, 1);
        tbl[11] = mk(1'b0, 0, 16, G, R, 1'b0, 2);
        // ped held through the walk phase: no second walk
        tbl[12] = mk(1'b0, 2,  4, G, R, 1'b0, 0);
        tbl[13] = mk(1'b0, 2,  8, Y, R, 1'b0, 1);
        tbl[14] = mk(1'b0, 2,  4, R, R, 1'b0, 0);
        tbl[15] = mk(1'b0, 2,  8, R, R, 1'b1, 1);
        tbl[16] = mk(1'b0, 0, 20, G, R, 1'b0, 2);
        // pressed again after exit
        tbl[17] = mk(1'b0, 1,  4, G, R, 1'b0, 0);
        tbl[18] = mk(1'b0, 0,  8, Y, R, 1'b0, 1);
        tbl[19] = mk(1'b0, 0,  4, R, R, 1'b0, 0);
        tbl[20] = mk(1'b0, 0,  8, R, R, 1'b1, 1);
        // car then ped during EW green: walk follows ALLRED_2
        tbl[21] = mk(1'b1, 0, 12, G, R, 1'b0, 2);
        tbl[22] = mk(1'b1, 0,  8, Y, R, 1'b0, 1);
        tbl[23] = mk(1'b1, 0,  4, R, R, 1'b0, 0);
        tbl[24] = mk(1'b0, 1,  8, R, G, 1'b0, 1);
        tbl[25] = mk(1'b0, 0,  8, R, Y, 1'b0, 1);
        tbl[26] = mk(1'b0, 0,  4, R, R, 1'b0, 0);
        tbl[27] = mk(1'b0, 0,  8, R, R, 1'b1, 1);
        tbl[28] = mk(1'b0, 0, 12, G, R, 1'b0, 2);

        // Idle after reset: green rests, countdown 2,1,0 then holds
        do_reset();
        chk("rst_ew", 32'(ew_lamp), 32'(R));
        chk("rst_walk", 32'(walk), 32'd0);
        for (int c = 0; c < 100; c++) begin
            e = 2 - c / 4;
            if (e < 0) e = 0;
            chk($sformatf("idle_ns c%0d", c), 32'(ns_lamp), 32'(G));
            chk($sformatf("idle_cd c%0d", c), 32'(cd), 32'(e));
            chk($sformatf("idle_tick c%0d", c), 32'(tick), 32'((c % 4) == 3));
            @(negedge clk);
        end

        // Table-driven phase sequences
        do_reset();
        for (int i = 0; i < 29; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                car = tbl[i].car;
                ped = (tbl[i].ped == 2) || ((tbl[i].ped == 1) && (k == 0));
                e = tbl[i].cd0 - k / 4;
                if (e < 0) e = 0;
                chk($sformatf("v%0d.%0d ns", i, k), 32'(ns_lamp), 32'(tbl[i].ns));
                chk($sformatf("v%0d.%0d ew", i, k), 32'(ew_lamp), 32'(tbl[i].ew));
                chk($sformatf("v%0d.%0d walk", i, k), 32'(walk), 32'(tbl[i].walk));
                chk($sformatf("v%0d.%0d cd", i, k), 32'(cd), 32'(e));
                chk($sformatf("v%0d.%0d tick", i, k), 32'(tick), 32'((k % 4) == 3));
                chk($sformatf("v%0d.%0d excl", i, k),
                    32'((ns_lamp != R) && (ew_lamp != R)), 32'd0);
                @(negedge clk);
            end
        end

        // Reset pulse in the middle of EW green
        do_reset();
        car = 1'b1;
        repeat (26) @(negedge clk);
        chk("pre_rst_ew", 32'(ew_lamp), 32'(G));
        chk("pre_rst_cd", 32'(cd), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        car   = 1'b0;
        chk("mid_rst_ns", 32'(ns_lamp), 32'(G));
        chk("mid_rst_ew", 32'(ew_lamp), 32'(R));
        chk("mid_rst_cd", 32'(cd), 32'd2);
        chk("mid_rst_tick", 32'(tick), 32'd0);
        repeat (3) @(negedge clk);
        chk("mid_rst_tick3", 32'(tick), 32'd1);

`ifdef TLC_NIGHT_FLASH_EN
        // Night flash entered from ALLRED_2, left back through ALLRED_2
        do_reset();
        for (int c = 0; c <= 60; c++) begin
            car   = (c <= 23);
            night = (c >= 40) && (c < 52);
            if (c >= 44 && c < 56) begin
                chk($sformatf("fl_ns c%0d", c), 32'(ns_lamp),
                    32'((((c - 44) / 4) % 2 == 0) ? Y : O));
                chk($sformatf("fl_ew c%0d", c), 32'(ew_lamp),
                    32'((((c - 44) / 4) % 2 == 0) ? R : O));
                chk($sformatf("fl_cd c%0d", c), 32'(cd), 32'd0);
                chk($sformatf("fl_walk c%0d", c), 32'(walk), 32'd0);
            end else if (c >= 56 && c < 60) begin
                chk($sformatf("fl_ar2_ns c%0d", c), 32'(ns_lamp), 32'(R));
                chk($sformatf("fl_ar2_ew c%0d", c), 32'(ew_lamp), 32'(R));
            end else if (c == 60) begin
                chk("fl_back_ns", 32'(ns_lamp), 32'(G));
                chk("fl_back_cd", 32'(cd), 32'd2);
            end
            @(negedge clk);
        end
        night = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
